// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART receiver.
//   OS_RATE         clocks per bit (only 16 is supported)
//   SMP0/SMP1/SMP2  phases at which the three majority-vote samples are taken
//   DATA_BITS       payload bits per frame
//   rx_state_e      receiver FSM states
package uart_pkg;

  localparam int unsigned OS_RATE   = 16;
  localparam int unsigned SMP0      = 7;
  localparam int unsigned SMP1      = 8;
  localparam int unsigned SMP2      = 9;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: input synchronizer, falling-edge detector,
// per-bit phase counter and 3-sample majority vote.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   rx          raw serial line (asynchronous to clk)
//   active      FSM is inside a bit (START/DATA/PARITY/STOP): phase counter runs
//   start       restart the phase counter; the current cycle is phase 0
//   rx_s        synchronized line
//   fall        rx_s went 1 -> 0 this cycle
//   bit_valid   phase 9 of an active bit: bit_value holds the decided bit
//   bit_value   majority of the samples at phases 7, 8 and 9
//   bit_end     phase 15 of an active bit
module uart_rx_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic active,
  input  logic start,
  output logic rx_s,
  output logic fall,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_end
);
  import uart_pkg::*;

  logic       rx_meta_q;
  logic       rx_s_q;
  logic       rx_prev_q;
  logic [3:0] phase_q;
  logic       smp0_q;
  logic       smp1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      phase_q   <= 4'd0;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      // The detection cycle counts as phase 0, so the counter loads 1 after it.
      if (start) begin
        phase_q <= 4'd1;
      end else if (active) begin
        phase_q <= phase_q + 4'd1;
      end else begin
        phase_q <= 4'd0;
      end
      if (active && phase_q == 4'(SMP0)) smp0_q <= rx_s_q;
      if (active && phase_q == 4'(SMP1)) smp1_q <= rx_s_q;
    end
  end

  assign rx_s      = rx_s_q;
  assign fall      = rx_prev_q & ~rx_s_q;
  assign bit_valid = active && (phase_q == 4'(SMP2));
  // Third sample is the live synchronized value at phase 9.
  assign bit_value = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
  assign bit_end   = active && (phase_q == 4'(OS_RATE - 1));

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 16 clocks per bit: 1 start, 8 data (LSB first), optional
// parity, 1 stop. Each byte is presented on dataout with a one-cycle strobe.
// Build option: define UART_RX_PARITY_EN to expect a parity bit after bit 7;
// otherwise frames are 10 bits and dataerror is tied low.
// Ports:
//   clk, rst_n  16x baud clock and asynchronous active-low reset
//   rx          serial line, idles high
//   dataout     last received byte (held until the next frame completes)
//   rdsig       one-cycle pulse: frame with a good stop bit received
//   dataerror   one-cycle pulse with rdsig on parity mismatch
//   frameerror  one-cycle pulse: stop bit sampled low
//   idle        1 while receiving (busy), 0 when idle
module uart_rx_os16 #(
  parameter logic        PARITYMODE = 1'b0,
  parameter int unsigned OS_RATE    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       dataerror,
  output logic       frameerror,
  output logic       idle
);
  import uart_pkg::*;

  rx_state_e  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] dataout_q;
  logic       rdsig_q;
  logic       dataerror_q;
  logic       frameerror_q;
  logic       idle_q;

  logic rx_s, fall, bit_valid, bit_value, bit_end;
  logic active, start, parity_err;

  assign active = (state_q == StStart) || (state_q == StData) ||
                  (state_q == StParity) || (state_q == StStop);
  assign start  = (state_q == StIdle) && fall;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .active    (active),
    .start     (start),
    .rx_s      (rx_s),
    .fall      (fall),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .bit_end   (bit_end)
  );

  // Only the 16x rate is implemented; the parameter exists for interface parity.
  logic unused_cfg;
`ifdef UART_RX_PARITY_EN
  logic par_q;
  assign parity_err = par_q ^ (^shift_q) ^ PARITYMODE;
  assign unused_cfg = (OS_RATE != uart_pkg::OS_RATE);
`else
  assign parity_err = 1'b0;
  assign unused_cfg = (OS_RATE != uart_pkg::OS_RATE) ^ PARITYMODE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      dataout_q    <= 8'd0;
      rdsig_q      <= 1'b0;
      dataerror_q  <= 1'b0;
      frameerror_q <= 1'b0;
      idle_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      rdsig_q      <= 1'b0;
      dataerror_q  <= 1'b0;
      frameerror_q <= 1'b0;
      case (state_q)
        StIdle: begin
          bit_cnt_q <= 3'd0;
          if (fall) begin
            state_q <= StStart;
            idle_q  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_valid && bit_value) begin
            // False start: glitch shorter than half a bit.
            state_q <= StIdle;
            idle_q  <= 1'b0;
          end else if (bit_end) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_valid) shift_q <= {bit_value, shift_q[7:1]};
          if (bit_end) begin
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              bit_cnt_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_q   <= StParity;
`else
              state_q   <= StStop;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (bit_valid) par_q <= bit_value;
          if (bit_end) state_q <= StStop;
        end
`endif
        StStop: begin
          if (bit_valid) begin
            dataout_q <= shift_q;
            if (bit_value) begin
              // Leave at phase 9 so a start edge later in this bit is caught.
              rdsig_q     <= 1'b1;
              dataerror_q <= parity_err;
              state_q     <= StIdle;
              idle_q      <= 1'b0;
            end else begin
              frameerror_q <= 1'b1;
              state_q      <= StBreak;
            end
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dataout    = dataout_q;
  assign rdsig      = rdsig_q;
  assign dataerror  = dataerror_q;
  assign frameerror = frameerror_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: the stimulus process pushes the expected
// strobe (kind, byte, parity error, arrival cycle) when it starts a frame; the
// monitor pops and compares whenever rdsig or frameerror appears.
module tb_uart_rx_os16;

`ifdef UART_RX_PARITY_EN
  localparam int Lat = 172;
`else
  localparam int Lat = 156;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dataout;
  logic       rdsig, dataerror, frameerror, idle;

  uart_rx_os16 #(
    .PARITYMODE (1'b0),
    .OS_RATE    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .dataout    (dataout),
    .rdsig      (rdsig),
    .dataerror  (dataerror),
    .frameerror (frameerror),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fe;
    logic [7:0] data;
    logic       de;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic rdsig_prev = 1'b0;
  logic fe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller is at a negedge; returns at a negedge with rx left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                            input logic exp_de);
    exp_t e;
    rx = 1'b0;
    e.fe   = ~stop_bit;
    e.data = d;
    e.de   = stop_bit ? exp_de : 1'b0;
    e.t    = cyc + Lat;
    exp_q.push_back(e);
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    repeat (16) @(negedge clk);
`else
    if (par_bit === 1'bx) $display("parity bit ignored");
`endif
    rx = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  task automatic gap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rdsig || frameerror) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected strobe: rdsig=%b frameerror=%b data=%h, expected none",
                   rdsig, frameerror, dataout);
        end else begin
          e = exp_q.pop_front();
          check("rdsig", {31'd0, rdsig}, {31'd0, ~e.fe});
          check("frameerror", {31'd0, frameerror}, {31'd0, e.fe});
          check("dataout", {24'd0, dataout}, {24'd0, e.data});
          check("dataerror", {31'd0, dataerror}, {31'd0, e.de});
          check("strobe cycle", cyc, e.t);
        end
        check("single-cycle strobe", {31'd0, (rdsig & rdsig_prev) | (frameerror & fe_prev)},
              32'd0);
      end
      if (dataerror) check("dataerror with rdsig", {31'd0, rdsig}, 32'd1);
    end
    rdsig_prev <= rdsig;
    fe_prev    <= frameerror;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    check("reset dataout", {24'd0, dataout}, 32'h00);
    check("reset rdsig", {31'd0, rdsig}, 32'd0);
    check("reset dataerror", {31'd0, dataerror}, 32'd0);
    check("reset frameerror", {31'd0, frameerror}, 32'd0);
    check("reset idle", {31'd0, idle}, 32'd0);
    rst_n = 1'b1;
    gap(10);

    // Plain byte, latency checked by the monitor
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    gap(20);

    // 4-clock low glitch: false start, idle back to 0 by phase 10
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("glitch idle busy", {31'd0, idle}, 32'd1);
    repeat (7) @(negedge clk);
    check("glitch idle released", {31'd0, idle}, 32'd0);
    gap(20);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    gap(20);

    // Stop bit low, line held low: one frameerror, FSM parked until rx high
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("break busy", {31'd0, idle}, 32'd1);
    gap(20);
    check("break released", {31'd0, idle}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    gap(20);

    // Back-to-back, start edges 160 (or 176 with parity) clocks apart
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    gap(20);

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (16 * 4 + 8) @(negedge clk);
    check("busy before abort", {31'd0, idle}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort dataout", {24'd0, dataout}, 32'h00);
    check("abort idle", {31'd0, idle}, 32'd0);
    check("abort strobes", {29'd0, rdsig, dataerror, frameerror}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(16 * 8);
    check("abort no strobe", {31'd0, idle}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    gap(20);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even parity needs 1
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    gap(20);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    gap(20);
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
UART receiver paired with the team's 16x-oversampled transmitter. Runs on the same UART clock (16 clocks per bit). Receives 1 start bit, 8 data bits LSB first, an optional parity bit and 1 stop bit. Outputs each received byte with a one-cycle strobe and error flags for the host-side framing logic.

Parameters:
PARITYMODE, 1'b0, parity seed. Expected parity = XOR(data[7:0]) ^ PARITYMODE. A value of 0 selects even parity. Used only with UART_RX_PARITY_EN.
OS_RATE, 16, clocks per bit. Fixed value; only 16 is supported.

Ports:
clk  in  1  UART clock at 16x the baud rate. Single clock domain.
rst_n  in  1  Asynchronous, active-low reset.
rx  in  1  Serial line. Asynchronous to clk; idles high.
dataout  out  8  Last received byte. Holds its value until the next frame completes.
rdsig  out  1  One-cycle pulse when a frame with a valid stop bit completes.
dataerror  out  1  One-cycle pulse, coincident with rdsig, when parity mismatches. Stays 0 when parity is compiled out.
frameerror  out  1  One-cycle pulse when the stop bit samples low.
idle  out  1  Line-status flag, same sense as the transmitter: 1 = receiving (busy), 0 = idle.

Behaviour:
- Reset (async, rst_n low):
  - dataout=0, rdsig=0, dataerror=0, frameerror=0, idle=0.
  - Both synchronizer flops = 1; state = IDLE; bit counter = 0.
  - Reset asserted mid-frame aborts the frame with no strobes.
- Input conditioning: rx passes through a 2-flop synchronizer, giving rx_s. The edge detector compares rx_s with its previous value.
- Per-bit timing: a 4-bit phase counter runs 0..15 for each bit. Three samples are taken at phase 7, 8 and 9. The bit value is the majority of the three, decided at phase 9.
- State machine:
  - IDLE: idle=0. A falling edge on rx_s (prev 1, now 1->0) → START. The detection cycle is phase 0.
  - START: if the start majority is 1 (false start), go back to IDLE at phase 9 with no strobes. Otherwise continue; at phase 15 → DATA.
  - DATA: decide 8 bits and shift them in LSB first. After bit 7 at phase 15 → PARITY (feature on) or STOP.
  - PARITY: decide the parity bit; at phase 15 → STOP.
  - STOP, decision at phase 9:
    - Majority 1: dataout <= shift register, rdsig=1 and dataerror as computed, both for the next cycle only. Go straight to IDLE so the next start edge is detectable during the rest of the stop bit.
    - Majority 0: dataout is still updated, frameerror=1 for one cycle, rdsig stays 0 → BREAK.
  - BREAK: wait until rx_s=1, then → IDLE. Prevents a line held low from producing repeated frames.
- idle = 1 in START, DATA, PARITY, STOP and BREAK.
- Latency, without parity: rdsig is high exactly 154 clocks after the detection cycle (9*16+9+1), plus 2 clocks of synchronizer delay from the pin. With parity the figure is 170.
- Back-to-back frames: a start edge arriving at stop phase ≥10 must be accepted. Exactly 160 clocks between start edges must work with no lost byte.
- rdsig, dataerror and frameerror are never high for more than one consecutive cycle.
- rdsig and frameerror are mutually exclusive.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the frame contains a parity bit after bit 7.
  - dataerror = received parity ^ XOR(data) ^ PARITYMODE, sampled at the stop decision.
  - rdsig still pulses on a parity error.
- Undefined: the PARITY state is not built, the frame is 10 bits, and dataerror is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - OS_RATE=16;
  - sample phases SMP0=7, SMP1=8, SMP2=9;
  - DATA_BITS=8.
- Sub-module uart_rx_sampler contains:
  - the 2-flop synchronizer;
  - the falling-edge detector;
  - the phase counter;
  - the 3-sample majority vote.
  It outputs bit_valid at phase 9 and bit_value.
- The top level holds the FSM, the shift register and the strobes.

Test Plan:
- Drive 0x55, 8N1, 16 clocks/bit → dataout=0x55, rdsig high for 1 cycle, 154 clocks after detection; no error flags.
- Low glitch on rx lasting 4 clocks → no strobes; idle returns to 0 by phase 10; a following valid 0xA3 is received correctly.
- Frame 0x3C with stop bit driven low, rx held low for 40 more clocks, then high → frameerror pulses once, no rdsig, FSM stays in BREAK until rx high; next frame 0x81 received.
- Back-to-back 0xA3 then 0x3C with start edges exactly 160 clocks apart → two rdsig pulses with correct data.
- rst_n asserted at DATA bit 4 of 0xFF → all outputs 0 immediately; no rdsig; next frame 0x12 received correctly.
- UART_RX_PARITY_EN with PARITYMODE=0: send 0x07 with parity bit 0 → rdsig=1 and dataerror=1; send the same byte with parity bit 1 → dataerror=0.
